// File: rtl/activation_interpolator.sv
// activation_interpolator: three-stage valid/ready pipeline that drives a
// 16-entry activation LUT from the integer bits of x and linearly
// interpolates between base and next entries using x's fraction bits.
module activation_interpolator #(
  parameter  int DATA_W = 8,
  parameter  int FRAC_W = 4,
  localparam int ADDR_W = DATA_W - FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [DATA_W-1:0] in_data,
  output logic        [ADDR_W-1:0] lut_addr,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy
);

  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam int SUM_W  = DATA_W + 2;

  logic                     en;

  logic                     v1_q, v1_d;
  logic        [ADDR_W-1:0] addr_q, addr_d;
  logic        [FRAC_W-1:0] frac1_q, frac1_d;

  logic                     v2_q, v2_d;
  logic signed [DATA_W-1:0] base_q, base_d;
  logic        [FRAC_W-1:0] frac2_q, frac2_d;
  logic signed [DIFF_W-1:0] diff_q, diff_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic signed [PROD_W-1:0] diff_ext;
  logic signed [PROD_W-1:0] frac_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [SUM_W-1:0]  sum;
  logic                     in_range;
  logic signed [DATA_W-1:0] sat_sum;

  // Whole pipeline advances together; it freezes only when the output is stalled.
  always_comb begin
    en = ~(out_valid_q & ~out_ready);
  end

  // Stage-3 arithmetic: floor-interpolate, widen, then clamp to DATA_W signed.
  always_comb begin
    diff_ext = PROD_W'(diff_q);
    frac_ext = PROD_W'({1'b0, frac2_q});
    prod     = diff_ext * frac_ext;
    shifted  = prod >>> FRAC_W;
    sum      = SUM_W'(base_q) + SUM_W'(shifted);
    in_range = (&sum[SUM_W-1:DATA_W-1]) | ~(|sum[SUM_W-1:DATA_W-1]);
    if (in_range) begin
      sat_sum = sum[DATA_W-1:0];
    end else if (sum[SUM_W-1]) begin
      sat_sum = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_sum = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Next-state for all stages; data registers load only behind a valid.
  always_comb begin
    v1_d        = v1_q;
    addr_d      = addr_q;
    frac1_d     = frac1_q;
    v2_d        = v2_q;
    base_d      = base_q;
    frac2_d     = frac2_q;
    diff_d      = diff_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en) begin
      v1_d = in_valid;
      if (in_valid) begin
        addr_d  = in_data[DATA_W-1:FRAC_W];
        frac1_d = in_data[FRAC_W-1:0];
      end
      v2_d = v1_q;
      if (v1_q) begin
        base_d  = lut_base;
        frac2_d = frac1_q;
        diff_d  = DIFF_W'(lut_next) - DIFF_W'(lut_base);
      end
      out_valid_d = v2_q;
      if (v2_q) begin
        out_data_d = sat_sum;
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      addr_q      <= '0;
      frac1_q     <= '0;
      v2_q        <= 1'b0;
      base_q      <= '0;
      frac2_q     <= '0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      addr_q      <= addr_d;
      frac1_q     <= frac1_d;
      v2_q        <= v2_d;
      base_q      <= base_d;
      frac2_q     <= frac2_d;
      diff_q      <= diff_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = en;
  assign lut_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = v1_q | v2_q | out_valid_q;

endmodule
